// File: rtl/snake_food_placer.sv
// ---------------------------------------------------------------------------
// snake_food_placer: picks the next food cell, probing past snake body cells
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module snake_food_placer #(
  parameter int unsigned       CELL_W     = 8,
  parameter int unsigned       LEN_W      = 5,
  parameter int unsigned       MAX_LEN    = 16,
  parameter int unsigned       MAX_PROBES = 256,
  parameter logic [CELL_W-1:0] SEED       = 8'hB8,
  parameter logic [CELL_W-1:0] FOOD_INIT  = 8'h88
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [LEN_W-1:0]           Length,
  input  logic                       Seed_en,
  input  logic [CELL_W-1:0]          Seed,
  output logic [$clog2(MAX_LEN)-1:0] Rd_addr,
  input  logic [CELL_W-1:0]          Rd_data,
  output logic [CELL_W-1:0]          Food,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Fail
);

  localparam int unsigned ADDR_W = $clog2(MAX_LEN);
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned PRB_W  = $clog2(MAX_PROBES + 1);
  localparam int unsigned CMP_W  = (LEN_W > CNT_W) ? LEN_W : CNT_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_PROBE = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t              r_state;
  logic [CELL_W-1:0]   r_lfsr;
  logic [CELL_W-1:0]   r_cand;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_next;
  logic [PRB_W-1:0]    r_probes;
  logic                r_issue;
  logic                r_cmp_valid;
  logic [ADDR_W-1:0]   r_cmp_idx;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [CELL_W-1:0]   r_food;
  logic                r_busy;
  logic                r_done;
  logic                r_fail;

  logic                w_lfsr_fb;
  logic [CELL_W-1:0]   w_seed_load;
  logic [CNT_W-1:0]    w_len_clamp;
  logic [CELL_W-1:0]   w_start_cand;
  logic                w_hit;
  logic                w_cmp_last;

  // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
  assign w_lfsr_fb    = r_lfsr[CELL_W-1] ^ r_lfsr[CELL_W-3] ^ r_lfsr[CELL_W-4] ^ r_lfsr[CELL_W-5];
  assign w_seed_load  = (Seed == '0) ? CELL_W'(1) : Seed;
  assign w_start_cand = Seed_en ? Seed : r_lfsr;

  always_comb begin
    w_len_clamp = CNT_W'(Length);
    if (CMP_W'(Length) > CMP_W'(MAX_LEN)) begin
      w_len_clamp = CNT_W'(MAX_LEN);
    end
  end

  // Rd_data always belongs to the address issued one cycle earlier
  assign w_hit      = r_cmp_valid && (Rd_data == r_cand);
  assign w_cmp_last = (CNT_W'(r_cmp_idx) == (r_len - CNT_W'(1)));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED;
      r_cand      <= '0;
      r_len       <= '0;
      r_next      <= '0;
      r_probes    <= '0;
      r_issue     <= 1'b0;
      r_cmp_valid <= 1'b0;
      r_cmp_idx   <= '0;
      r_rd_addr   <= '0;
      r_food      <= FOOD_INIT;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_fail <= 1'b0;

      if (Seed_en) begin
        r_lfsr <= w_seed_load;
      end else begin
        r_lfsr <= {r_lfsr[CELL_W-2:0], w_lfsr_fb};
      end

      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_cand      <= w_start_cand;
            r_len       <= w_len_clamp;
            r_probes    <= PRB_W'(1);
            r_next      <= CNT_W'(1);
            r_issue     <= 1'b1;
            r_cmp_valid <= 1'b0;
            r_cmp_idx   <= '0;
            if (w_len_clamp == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_food  <= w_start_cand;
            end else begin
              r_state   <= S_SCAN;
              r_busy    <= 1'b1;
              r_rd_addr <= '0;
            end
          end
        end

        S_SCAN: begin
          if (w_hit) begin
            r_state <= S_PROBE;
          end else if (r_cmp_valid && w_cmp_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_food  <= r_cand;
          end else begin
            r_cmp_valid <= r_issue;
            r_cmp_idx   <= r_rd_addr;
            if (r_next < r_len) begin
              r_rd_addr <= r_next[ADDR_W-1:0];
              r_next    <= r_next + CNT_W'(1);
              r_issue   <= 1'b1;
            end else begin
              r_issue <= 1'b0;
            end
          end
        end

        S_PROBE: begin
          r_cand <= r_cand + CELL_W'(1);
          if (r_probes == PRB_W'(MAX_PROBES)) begin
            r_state <= S_FAIL;
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_probes    <= r_probes + PRB_W'(1);
            r_state     <= S_SCAN;
            r_rd_addr   <= '0;
            r_next      <= CNT_W'(1);
            r_issue     <= 1'b1;
            r_cmp_valid <= 1'b0;
          end
        end

        S_DONE:  r_state <= S_IDLE;
        S_FAIL:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Rd_addr = r_rd_addr;
  assign Food    = r_food;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Fail    = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_snake_food_placer.sv
// ---------------------------------------------------------------------------
// tb_snake_food_placer: two instances (256 and 2 probes) vs. a cycle-count model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_snake_food_placer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Seed_en = 1'b0;
  logic [4:0] Length = '0;
  logic [7:0] Seed = '0;

  logic [3:0] rd_addr [2];
  logic [7:0] rd_data [2];
  logic [7:0] food    [2];
  logic       busy    [2];
  logic       done    [2];
  logic       fail    [2];

  logic [7:0] body [16];
  logic [7:0] m_lfsr;
  logic [7:0] food_prev [2];

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         exp_ok   [2];
  logic [7:0] exp_food [2];
  int         exp_lat  [2];
  int         exp_addr [2][0:1023];

  always #5 Clk = ~Clk;

  snake_food_placer u_dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Length(Length),
    .Seed_en(Seed_en), .Seed(Seed), .Rd_addr(rd_addr[0]), .Rd_data(rd_data[0]),
    .Food(food[0]), .Busy(busy[0]), .Done(done[0]), .Fail(fail[0])
  );

  snake_food_placer #(.MAX_PROBES(2)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Length(Length),
    .Seed_en(Seed_en), .Seed(Seed), .Rd_addr(rd_addr[1]), .Rd_data(rd_data[1]),
    .Food(food[1]), .Busy(busy[1]), .Done(done[1]), .Fail(fail[1])
  );

  // Registered body-array read port, one per instance
  always @(posedge Clk) begin
    rd_data[0] <= body[rd_addr[0]];
    rd_data[1] <= body[rd_addr[1]];
  end

  // Polynomial x^8+x^6+x^5+x^4+1: new LSB is the XOR of bits 7,5,4,3
  always @(posedge Clk) begin
    if (!Reset)       m_lfsr <= 8'hB8;
    else if (Seed_en) m_lfsr <= (Seed == 8'h00) ? 8'h01 : Seed;
    else              m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks candidates over the body and predicts outcome, result cycle and
  // the Rd_addr seen in every busy cycle (cycle 1 = first cycle after Start).
  task automatic model(input int w, input logic [7:0] c0, input int ln, input int maxp);
    logic [7:0] c;
    int s, probes, k;
    bit fin;
    c = c0; s = 1; probes = 1; fin = 0;
    if (ln == 0) begin
      exp_ok[w] = 1; exp_food[w] = c0; exp_lat[w] = 1;
    end else begin
      while (!fin) begin
        k = -1;
        for (int i = 0; i < ln; i++) if (k < 0 && body[i] == c) k = i;
        if (k < 0) begin
          for (int j = 0; j <= ln; j++) exp_addr[w][s+j] = (j < ln - 1) ? j : ln - 1;
          exp_ok[w] = 1; exp_food[w] = c; exp_lat[w] = s + ln + 1; fin = 1;
        end else begin
          for (int j = 0; j <= k + 1; j++) exp_addr[w][s+j] = (j < ln - 1) ? j : ln - 1;
          exp_addr[w][s+k+2] = (k + 1 < ln - 1) ? k + 1 : ln - 1;
          if (probes == maxp) begin
            exp_ok[w] = 0; exp_food[w] = food_prev[w]; exp_lat[w] = s + k + 3; fin = 1;
          end else begin
            probes++; c = c + 8'd1; s = s + k + 3;
          end
        end
      end
    end
  endtask

  task automatic run_txn(input bit en, input logic [7:0] sd, input int length, input bit hold);
    logic [7:0] c;
    int ln, nmax, nmin;
    @(negedge Clk);
    Start = 1'b1; Seed_en = en; Seed = sd; Length = length[4:0];
    c  = en ? sd : m_lfsr;
    ln = (length > 16) ? 16 : length;
    model(0, c, ln, 256);
    model(1, c, ln, 2);
    nmax = (exp_lat[0] > exp_lat[1]) ? exp_lat[0] : exp_lat[1];
    nmin = (exp_lat[0] < exp_lat[1]) ? exp_lat[0] : exp_lat[1];
    @(posedge Clk);
    #1;
    Start = hold; Seed_en = 1'b0;
    Length = 5'(($urandom_range(0, 31)));
    for (int n = 1; n <= nmax + 1; n++) begin
      @(negedge Clk);
      if (n == nmin) Start = 1'b0;
      for (int w = 0; w < 2; w++) begin
        if (n < exp_lat[w]) begin
          check($sformatf("busy[%0d]@%0d", w, n), busy[w], 1);
          check($sformatf("done_early[%0d]@%0d", w, n), done[w], 0);
          check($sformatf("fail_early[%0d]@%0d", w, n), fail[w], 0);
          check($sformatf("food_hold[%0d]@%0d", w, n), food[w], food_prev[w]);
          check($sformatf("rd_addr[%0d]@%0d", w, n), rd_addr[w], exp_addr[w][n]);
        end else if (n == exp_lat[w]) begin
          check($sformatf("done[%0d]@%0d", w, n), done[w], exp_ok[w]);
          check($sformatf("fail[%0d]@%0d", w, n), fail[w], !exp_ok[w]);
          check($sformatf("busy_end[%0d]@%0d", w, n), busy[w], 0);
          check($sformatf("food[%0d]@%0d", w, n), food[w], exp_food[w]);
        end else if (n == exp_lat[w] + 1) begin
          check($sformatf("done_pulse[%0d]", w), done[w], 0);
          check($sformatf("fail_pulse[%0d]", w), fail[w], 0);
          check($sformatf("busy_idle[%0d]", w), busy[w], 0);
        end
      end
    end
    food_prev[0] = exp_food[0];
    food_prev[1] = exp_food[1];
    Start = 1'b0;
  endtask

  initial begin
    logic [7:0] base;
    for (int i = 0; i < 16; i++) body[i] = 8'(i);
    food_prev[0] = 8'h88;
    food_prev[1] = 8'h88;

    // Reset held for two edges
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rst_food[%0d]", w), food[w], 8'h88);
      check($sformatf("rst_busy[%0d]", w), busy[w], 0);
      check($sformatf("rst_done[%0d]", w), done[w], 0);
      check($sformatf("rst_fail[%0d]", w), fail[w], 0);
      check($sformatf("rst_addr[%0d]", w), rd_addr[w], 0);
    end
    Reset = 1'b1;

    // First LFSR value after release is one step from 8'hB8
    run_txn(0, 8'h00, 0, 0);
    check("lfsr_first_step", food[0], 8'h70);

    // No collision, explicit seed
    body[0] = 8'h20; body[1] = 8'h21; body[2] = 8'h22;
    run_txn(1, 8'h7D, 3, 0);
    check("seed_7d_food", food[0], 8'h7D);

    // Two consecutive collisions
    run_txn(1, 8'h21, 3, 0);
    check("probe_food", food[0], 8'h23);

    // Candidate wraps 8'hFF -> 8'h00
    body[0] = 8'hFF;
    run_txn(1, 8'hFF, 1, 0);
    check("wrap_food", food[0], 8'h00);

    // Probe exhaustion on the 2-probe instance, Start held during Busy
    body[0] = 8'h10; body[1] = 8'h11;
    run_txn(1, 8'h10, 2, 1);
    check("fail_food_unchanged", food[1], 8'h00);
    check("noexhaust_food", food[0], 8'h12);

    // Zero length and over-length clamp
    run_txn(1, 8'h3C, 0, 0);
    check("len0_food", food[0], 8'h3C);
    for (int i = 0; i < 16; i++) body[i] = 8'(i);
    run_txn(1, 8'h80, 20, 0);

    // Reset in the middle of a scan
    @(negedge Clk);
    Start = 1'b1; Seed_en = 1'b1; Seed = 8'h50; Length = 5'd10;
    @(posedge Clk);
    #1;
    Start = 1'b0; Seed_en = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    for (int w = 0; w < 2; w++) begin
      check($sformatf("midrst_food[%0d]", w), food[w], 8'h88);
      check($sformatf("midrst_busy[%0d]", w), busy[w], 0);
      check($sformatf("midrst_addr[%0d]", w), rd_addr[w], 0);
      food_prev[w] = 8'h88;
    end
    repeat (12) begin
      @(negedge Clk);
      for (int w = 0; w < 2; w++) begin
        check($sformatf("midrst_nodone[%0d]", w), done[w], 0);
        check($sformatf("midrst_nofail[%0d]", w), fail[w], 0);
      end
    end

    // Randomized transactions clustered to provoke collisions
    for (int t = 0; t < 24; t++) begin
      base = 8'($urandom);
      for (int i = 0; i < 16; i++) body[i] = base + 8'($urandom_range(0, 6));
      run_txn($urandom_range(0, 3) != 0, base + 8'($urandom_range(0, 6)),
              $urandom_range(0, 20), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/snake_food_placer.md
Name: snake_food_placer

Overview:
- Controller that picks the next food cell for the snake game.
- It scans the snake body-location array through a shared read port, so it never places food under the snake.
- The first candidate comes from a free-running 8-bit LFSR. On each collision the candidate is linearly probed (+1, mod 256).
- Sits between the core state machine (issues Start on eat/init, consumes Food/Done) and the body-location storage.

Parameters:
- CELL_W, 8, cell index width (16x16 grid, 256 cells, row-major).
- LEN_W, 5, width of Length.
- MAX_LEN, 16, maximum body entries scanned; larger Length is clamped to this.
- MAX_PROBES, 256, candidate probes allowed before Fail.
- SEED, 8'hB8, LFSR reset value (must be nonzero).
- FOOD_INIT, 8'h88, Food value after reset.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  request new food; sampled only in IDLE.
- Length  in  LEN_W  current body length, latched at accepted Start.
- Seed_en  in  1  force LFSR load this cycle.
- Seed  in  CELL_W  value loaded when Seed_en=1 (8'h00 loads 8'h01).
- Rd_addr  out  4  body-array index (log2 MAX_LEN bits).
- Rd_data  in  CELL_W  body location at Rd_addr, valid one cycle after the address (registered read).
- Food  out  CELL_W  placed food cell; updated only when Done is asserted.
- Busy  out  1  high from the cycle after accepted Start until the DONE/FAIL cycle (exclusive).
- Done  out  1  one-cycle pulse; Food valid from this cycle.
- Fail  out  1  one-cycle pulse; probes exhausted, Food unchanged.

Behaviour:
- Reset (Reset=0 at a rising edge) forces:
  - state=IDLE, Food=FOOD_INIT, Busy=0, Done=0, Fail=0, Rd_addr=0, LFSR=SEED.
  - This applies mid-scan too: the scan is abandoned and there is no Done/Fail.
- LFSR:
  - Fibonacci, taps x^8+x^6+x^5+x^4+1, steps every cycle out of reset in all states. Never zero.
  - Seed_en overrides the step.
- States: IDLE, SCAN, PROBE, DONE, FAIL.
- IDLE:
  - When Start=1 at cycle T: cand <= LFSR current value, or Seed if Seed_en=1 in the same cycle.
  - Also at T: len <= min(Length, MAX_LEN), probe count <= 1, idx <= 0.
  - If len==0, go to DONE; otherwise go to SCAN.
- SCAN:
  - Drives Rd_addr=idx and increments idx while idx<len.
  - Each cycle compares Rd_data (for address issued the previous cycle) against cand.
  - Match: go to PROBE. In-flight reads are discarded.
  - Compare of index len-1 with no match: go to DONE.
- PROBE (1 cycle):
  - cand <= cand+1 (8-bit wrap: 8'hFF -> 8'h00), idx <= 0.
  - If probe count == MAX_PROBES, go to FAIL; else probe count += 1 and go to SCAN.
- DONE (1 cycle): Food <= cand (visible the same cycle Done=1); Done=1, Busy=0; then IDLE.
- FAIL (1 cycle): Fail=1, Busy=0, Food unchanged; then IDLE.
- Latency, no collision, Start at T with len=L≥1:
  - Rd_addr 0..L-1 driven in T+1..T+L; compares in T+2..T+L+1.
  - Done at T+L+2.
- Latency, len=0: Done at T+1.
- Each collision detected in compare cycle c adds PROBE at c+1; rescan starts with Rd_addr=0 at c+2.
- Start ignored when state≠IDLE (including the DONE/FAIL cycle). Length changes during Busy are ignored.
- Rd_addr holds its last value when not in SCAN.

Test Plan:
1. Reset=0 for 2 cycles, then release -> Food=8'h88, Busy=0, Done=0, Fail=0; LFSR first step from 8'hB8 matches the model.
2. Seed_en=1, Seed=8'h7D, Start=1 at T, Length=3, body={8'h20,8'h21,8'h22} -> Rd_addr 0,1,2 in T+1..T+3; Done at T+5 with Food=8'h7D; Busy high T+1..T+4.
3. Seed 8'h21, Length=3, body={8'h20,8'h21,8'h22} -> collision at index 1; rescans 8'h22 (collides at index 2), then 8'h23 -> Done with Food=8'h23.
4. Seed 8'hFF, Length=1, body={8'hFF} -> wraps to 8'h00 -> Food=8'h00, Done.
5. MAX_PROBES=2, Seed 8'h10, Length=2, body={8'h10,8'h11} -> Fail pulse after the second PROBE; Food unchanged; Start held during Busy ignored.
6. Length=0 -> Done at T+1 with Food=Seed. Length=20 -> exactly 16 reads. Reset=0 mid-SCAN -> no Done, state IDLE, Food=8'h88.
